// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, digit counts and the saturation value.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          BCD_DIGITS     = 4;
    localparam int          SCRATCH_DIGITS = 5;
    localparam logic [15:0] BCD_MAX        = 16'h9999;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    // Inputs are always <= 9, so the 4-bit sum never wraps.
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, DIN_W iterations).
// Optional build macro BCD_SATURATE_EN: overflowing values show 9999.
module bin2bcd_conv
    import bcd_pkg::*;
#(
    parameter int DIN_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [DIN_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd,
    output logic             ovf
);

    localparam int SCR_W = 4 * SCRATCH_DIGITS;
    localparam int BCD_W = 4 * BCD_DIGITS;
    localparam int CNT_W = $clog2(DIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIN_W - 1);

    state_e             state_q, state_d;
    logic [DIN_W-1:0]   shift_q, shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [SCR_W-1:0]   scratch_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               ovf_now;
    logic [BCD_W-1:0]   bcd_now;

    for (genvar g = 0; g < SCRATCH_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scratch_q[4*g +: 4]),
            .q_o (scratch_adj[4*g +: 4])
        );
    end

    assign ovf_now = |scratch_q[SCR_W-1:BCD_W];

`ifdef BCD_SATURATE_EN
    assign bcd_now = ovf_now ? BCD_MAX : scratch_q[BCD_W-1:0];
`else
    assign bcd_now = scratch_q[BCD_W-1:0];
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = din;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                // Correct every nibble, then shift {scratch, shift} left by one.
                scratch_d = {scratch_adj[SCR_W-2:0], shift_q[DIN_W-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) state_d = ST_DONE;
            end
            ST_DONE: begin
                ovf_d   = ovf_now;
                bcd_d   = bcd_now;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q == ST_CONV);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed bench for bin2bcd_conv: reset, latency, boundaries, ignored and
// back-to-back starts, and mid-conversion reset.
module tb_bin2bcd_conv;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [15:0] din = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int done_cnt   = 0;

    bin2bcd_conv #(.DIN_W(16)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge. Drives one conversion and checks result,
    // latency and busy length; optionally injects starts that must be ignored.
    task automatic convert(input logic [15:0] val, input logic [15:0] exp_bcd,
                           input logic exp_ovf, input bit ign, output int done_at);
        int lat;
        int busy_cyc;
        bit seen;
        lat = 0; busy_cyc = 0; seen = 0; done_at = -1;
        din   = val;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                done_at = cyc;
                break;
            end
            if (busy) busy_cyc++;
            if (ign && (lat == 5 || lat == 16)) begin
                din   = 16'h7777;
                start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'd17);
        chk("busy_len", 32'(busy_cyc), 32'd16);
        chk("bcd", 32'(bcd), 32'(exp_bcd));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
    endtask

    logic [15:0] sat_10000, sat_65535;
    int t1, t2, dc0;

    initial begin
`ifdef BCD_SATURATE_EN
        sat_10000 = 16'h9999;
        sat_65535 = 16'h9999;
`else
        sat_10000 = 16'h0000;
        sat_65535 = 16'h5535;
`endif
        // Reset with activity on the inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din   = 16'($urandom);
            start = 1'($urandom);
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'd0);
        chk("rst_ovf",  32'(ovf),  32'd0);
        start = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);

        convert(16'd1234,  16'h1234, 1'b0, 0, t1);
        @(negedge clk);
        convert(16'd0,     16'h0000, 1'b0, 0, t1);
        @(negedge clk);
        convert(16'd9999,  16'h9999, 1'b0, 0, t1);
        @(negedge clk);
        convert(16'd10000, sat_10000, 1'b1, 0, t1);
        chk("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("bcd_held", 32'(bcd), 32'(sat_10000));
        chk("ovf_held", 32'(ovf), 32'd1);
        convert(16'd65535, sat_65535, 1'b1, 0, t1);
        @(negedge clk);

        // Starts during CONV and DONE must be dropped.
        dc0 = done_cnt;
        convert(16'd2468, 16'h2468, 1'b0, 1, t1);
        repeat (20) @(negedge clk);
        chk("ignored_no_extra_done", 32'(done_cnt - dc0), 32'd1);

        // Back-to-back: start raised in the done cycle.
        convert(16'd321, 16'h0321, 1'b0, 0, t1);
        convert(16'd8765, 16'h8765, 1'b0, 0, t2);
        chk("b2b_spacing", 32'(t2 - t1), 32'd18);
        @(negedge clk);

        // Reset 8 cycles into a conversion.
        din   = 16'd500;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        dc0 = done_cnt;
        clr = 1'b0;
        #1;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_bcd",  32'(bcd),  32'd0);
        chk("clr_ovf",  32'(ovf),  32'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (25) @(negedge clk);
        chk("clr_no_done", 32'(done_cnt - dc0), 32'd0);
        convert(16'd42, 16'h0042, 1'b0, 0, t1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
